chrono_core: RTL and testbench

- Parametrised successor to the fixed MM:SS timer core.
- Provides two run modes in one block: countdown timer and stopwatch with lap hold.
- Sits between the debounce wrapper (level button inputs) and the display driver / blinking display (minutes, seconds, blink).
- Time base comes from an external 1-cycle tick pulse produced by the clock divider.

---
 rtl/chrono_core.sv | 206 ++++++++++++++++++++
 tb/tb_chrono_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_core.sv
// MM:SS countdown timer / stopwatch with lap hold, driven by an external tick.
// Optional CHRONO_AUTO_REPEAT_EN adds hold-to-repeat on the adjust buttons.
module chrono_core #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MIN_W         = 6,
    parameter int MAX_MIN       = 59,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_RATE   = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
    input  logic             inc_min,
    input  logic             inc_sec,
    input  logic             inc,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic             running,
    output logic             blink,
    output logic             expired
);

    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);

    localparam int B_START = 5;
    localparam int B_STOP  = 4;
    localparam int B_RESET = 3;
    localparam int B_LAP   = 2;
    localparam int B_IMIN  = 1;
    localparam int B_ISEC  = 0;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPD} state_t;

    state_t           state, state_nx;
    logic [MIN_W-1:0] cnt_min, min_nx;
    logic [5:0]       cnt_sec, sec_nx;
    logic [SUB_W-1:0] sub, sub_nx;
    logic             hold, hold_nx;

    logic [5:0] btn_r, btn_p, rise;
    logic       mode_r, mode_p;
    logic       start_e, stop_e, reset_e, lap_e, mode_e;
    logic       imin_ev, isec_ev, clr, zero, adj;
    logic [1:0] rep;

    assign rise    = btn_r & ~btn_p;
    assign reset_e = rise[B_RESET];
    assign mode_e  = en & (mode_r != mode_p);
    assign stop_e  = en & rise[B_STOP];
    assign start_e = en & rise[B_START];
    assign lap_e   = en & rise[B_LAP];
    assign imin_ev = en & (rise[B_IMIN] | rep[1]);
    assign isec_ev = en & (rise[B_ISEC] | rep[0]);
    assign zero    = (cnt_min == '0) && (cnt_sec == 6'd0);
    assign adj     = (state == IDLE) || (state == PAUSE);
    assign clr     = reset_e | mode_e | ((state == EXPD) & (stop_e | start_e));

`ifdef CHRONO_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] LIM_D = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] LIM_R = RW'(REPEAT_RATE - 1);

    logic [1:0]    held, arm;
    logic [RW-1:0] rcnt [2];

    assign held = {btn_r[B_IMIN], btn_r[B_ISEC]};

    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
            rep[i] = en && tick && adj && held[i]
                  && (rcnt[i] == (arm[i] ? LIM_R : LIM_D));
        end
    end

    // Phase 1 waits the initial delay, phase 2 (arm) steps at the repeat rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm <= '0;
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!held[i] || reset_e) begin
                    rcnt[i] <= '0;
                    arm[i]  <= 1'b0;
                end else if (en && tick && adj) begin
                    if (rep[i]) begin
                        rcnt[i] <= '0;
                        arm[i]  <= 1'b1;
                    end else begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep = {2{(REPEAT_DELAY | REPEAT_RATE) < 0}};
`endif

    always_comb begin
        state_nx = state;
        min_nx   = cnt_min;
        sec_nx   = cnt_sec;
        sub_nx   = sub;
        hold_nx  = hold;

        if (en && tick && state == RUN) begin
            if (sub == SUB_MAX) begin
                sub_nx = '0;
                if (!mode_p) begin
                    if (cnt_sec == 6'd0) begin
                        sec_nx = 6'd59;
                        min_nx = cnt_min - 1'b1;
                    end else begin
                        sec_nx = cnt_sec - 1'b1;
                    end
                    if (cnt_min == '0 && cnt_sec == 6'd1) state_nx = EXPD;
                end else if (cnt_min == MIN_MAX && cnt_sec == 6'd59) begin
                    state_nx = PAUSE;
                end else if (cnt_sec == 6'd59) begin
                    sec_nx = 6'd0;
                    min_nx = cnt_min + 1'b1;
                end else begin
                    sec_nx = cnt_sec + 1'b1;
                end
            end else begin
                sub_nx = sub + 1'b1;
            end
        end

        if (clr) begin
            state_nx = IDLE;
            min_nx   = '0;
            sec_nx   = 6'd0;
            sub_nx   = '0;
            hold_nx  = 1'b0;
        end else if (stop_e) begin
            if (state == RUN && state_nx == RUN) state_nx = PAUSE;
        end else if (start_e) begin
            if (adj && !(!mode_p && zero)) begin
                state_nx = RUN;
                if (state == IDLE) sub_nx = '0;
            end
        end else if (lap_e) begin
            if (mode_p && (state == RUN || state == PAUSE)) hold_nx = !hold;
        end else if (imin_ev) begin
            if (adj) begin
                if (inc) min_nx = (cnt_min == MIN_MAX) ? '0 : cnt_min + 1'b1;
                else     min_nx = (cnt_min == '0) ? MIN_MAX : cnt_min - 1'b1;
            end
        end else if (isec_ev) begin
            if (adj) begin
                if (inc) sec_nx = (cnt_sec == 6'd59) ? 6'd0 : cnt_sec + 1'b1;
                else     sec_nx = (cnt_sec == 6'd0) ? 6'd59 : cnt_sec - 1'b1;
            end
        end
    end

    // Display registers freeze while the lap hold stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_min <= '0;
            cnt_sec <= 6'd0;
            sub     <= '0;
            hold    <= 1'b0;
            btn_r   <= '0;
            btn_p   <= '0;
            mode_r  <= 1'b0;
            mode_p  <= 1'b0;
            minutes <= '0;
            seconds <= 6'd0;
            running <= 1'b0;
            blink   <= 1'b0;
            expired <= 1'b0;
        end else begin
            btn_r   <= {start, stop, reset, lap, inc_min, inc_sec};
            btn_p   <= btn_r;
            mode_r  <= mode;
            if (en) mode_p <= mode_r;
            state   <= state_nx;
            cnt_min <= min_nx;
            cnt_sec <= sec_nx;
            sub     <= sub_nx;
            hold    <= hold_nx;
            if (!hold || !hold_nx) begin
                minutes <= min_nx;
                seconds <= sec_nx;
            end
            running <= (state_nx == RUN);
            blink   <= (state_nx == PAUSE) || (state_nx == EXPD) || hold_nx;
            expired <= (state_nx == EXPD);
        end
    end

endmodule

// File: tb/tb_chrono_core.sv
// Directed scoreboard bench for chrono_core (timer, stopwatch, lap, adjust).
// Expected display states are queued with each stimulus step and popped on check.
module tb_chrono_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       reset = 1'b0;
    logic       lap = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_sec = 1'b0;
    logic       inc = 1'b1;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       blink;
    logic       expired;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t sb[$];

    chrono_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tick    (tick),
        .mode    (mode),
        .start   (start),
        .stop    (stop),
        .reset   (reset),
        .lap     (lap),
        .inc_min (inc_min),
        .inc_sec (inc_sec),
        .inc     (inc),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .blink   (blink),
        .expired (expired)
    );

    always #20 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press(input int b);
        case (b)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: reset = 1'b1;
            3: lap = 1'b1;
            4: inc_min = 1'b1;
            default: inc_sec = 1'b1;
        endcase
        cyc(3);
        {start, stop, reset, lap, inc_min, inc_sec} = '0;
        cyc(3);
    endtask

    task automatic push(input string tag, input int m, input int s,
                        input logic r, input logic b, input logic e);
        exp_t x;
        x.tag = tag;
        x.v = {6'(m), 6'(s), r, b, e};
        sb.push_back(x);
    endtask

    task automatic compare();
        exp_t x;
        logic [14:0] obs;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        x = sb.pop_front();
        obs = {minutes, seconds, running, blink, expired};
        assert (obs === x.v) else begin
            failures++;
            $error("FAIL %s observed=%0d:%0d r%0b b%0b e%0b expected=%0d:%0d r%0b b%0b e%0b",
                   x.tag, obs[14:9], obs[8:3], obs[2], obs[1], obs[0],
                   x.v[14:9], x.v[8:3], x.v[2], x.v[1], x.v[0]);
        end
    endtask

    task automatic step(input string tag, input int m, input int s,
                        input logic r, input logic b, input logic e);
        push(tag, m, s, r, b, e);
        compare();
    endtask

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_RESET = 2;
    localparam int P_LAP   = 3;
    localparam int P_IMIN  = 4;
    localparam int P_ISEC  = 5;

    initial begin
        cyc(2);
        step("reset_state", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        en = 1'b1;
        cyc(4);

        inc = 1'b1;
        press(P_ISEC);
        press(P_ISEC);
        press(P_ISEC);
        step("timer_set", 0, 3, 0, 0, 0);
        press(P_START);
        step("timer_run", 0, 3, 1, 0, 0);
        ticks(2999);
        step("timer_pre_expire", 0, 1, 1, 0, 0);
        ticks(1);
        step("timer_expired", 0, 0, 0, 1, 1);
        press(P_START);
        step("timer_clear", 0, 0, 0, 0, 0);
        press(P_START);
        step("timer_zero_start", 0, 0, 0, 0, 0);

        mode = 1'b1;
        cyc(4);
        press(P_START);
        ticks(2000);
        step("sw_2s", 0, 2, 1, 0, 0);
        press(P_LAP);
        step("lap_hold", 0, 2, 1, 1, 0);
        ticks(3000);
        step("lap_frozen", 0, 2, 1, 1, 0);
        press(P_LAP);
        step("lap_release", 0, 5, 1, 0, 0);

        press(P_RESET);
        step("soft_reset", 0, 0, 0, 0, 0);
        press(P_START);
        ticks(1500);
        press(P_STOP);
        step("pause", 0, 1, 0, 1, 0);
        press(P_START);
        step("resume", 0, 1, 1, 0, 0);
        ticks(499);
        step("resume_pre", 0, 1, 1, 0, 0);
        ticks(1);
        step("resume_sub_kept", 0, 2, 1, 0, 0);

        press(P_RESET);
        inc = 1'b0;
        press(P_ISEC);
        step("sec_wrap_down", 0, 59, 0, 0, 0);
        press(P_IMIN);
        step("min_wrap_down", 59, 59, 0, 0, 0);
        inc = 1'b1;
        press(P_ISEC);
        step("sec_wrap_up_no_carry", 59, 0, 0, 0, 0);
        press(P_IMIN);
        step("min_wrap_up", 0, 0, 0, 0, 0);
        press(P_START);
        step("sw_run_zero", 0, 0, 1, 0, 0);
        press(P_IMIN);
        step("adjust_in_run", 0, 0, 1, 0, 0);
        ticks(1000);
        step("sw_1s", 0, 1, 1, 0, 0);

        start = 1'b1;
        reset = 1'b1;
        cyc(3);
        start = 1'b0;
        reset = 1'b0;
        cyc(3);
        step("reset_beats_start", 0, 0, 0, 0, 0);

        press(P_START);
        ticks(1200);
        step("pre_async_rst", 0, 1, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        step("async_rst", 0, 0, 0, 0, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);

        inc = 1'b0;
        press(P_IMIN);
        press(P_ISEC);
        press(P_ISEC);
        step("preset_59_58", 59, 58, 0, 0, 0);
        press(P_START);
        ticks(1000);
        step("sat_59_59", 59, 59, 1, 0, 0);
        ticks(1000);
        step("saturate_pause", 59, 59, 0, 1, 0);

        en = 1'b0;
        press(P_START);
        ticks(1000);
        step("en_low_hold", 59, 59, 0, 1, 0);
        press(P_RESET);
        step("en_low_reset", 0, 0, 0, 0, 0);
        en = 1'b1;
        cyc(2);

        inc = 1'b1;
        inc_sec = 1'b1;
        cyc(3);
        ticks(999);
        inc_sec = 1'b0;
        cyc(3);
`ifdef CHRONO_AUTO_REPEAT_EN
        step("auto_repeat", 0, 6, 0, 0, 0);
`else
        step("held_single_step", 0, 1, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
